// File: rtl/ftsd_scan_rx_pkg.sv
// Shared constants and types for the four-digit display scan interface.
// The transmit-side scan controller uses the same select codes.
package ftsd_scan_rx_pkg;

  localparam int BCD_BIT_WIDTH           = 4;
  localparam int FTSD_NUM                = 4;
  localparam int FTSD_SCAN_CTL_BIT_WIDTH = 2;

  // Active-low one-cold digit selects.
  localparam logic [FTSD_NUM-1:0] FTSD_SEL_DIG0 = 4'b0111;
  localparam logic [FTSD_NUM-1:0] FTSD_SEL_DIG1 = 4'b1011;
  localparam logic [FTSD_NUM-1:0] FTSD_SEL_DIG2 = 4'b1101;
  localparam logic [FTSD_NUM-1:0] FTSD_SEL_DIG3 = 4'b1110;
  localparam logic [FTSD_NUM-1:0] FTSD_BLANK    = 4'b1111;

  typedef struct packed {
    logic                               valid;
    logic                               blank;
    logic [FTSD_SCAN_CTL_BIT_WIDTH-1:0] idx;
  } ftsd_sel_t;

endpackage

// File: rtl/ftsd_sel_decode.sv
// Combinational decode of an active-low digit select into {valid, blank, idx}.
// Shared with the display-side checker.
module ftsd_sel_decode
  import ftsd_scan_rx_pkg::*;
(
  input  logic [FTSD_NUM-1:0]                sel,
  output logic                               valid,
  output logic                               blank,
  output logic [FTSD_SCAN_CTL_BIT_WIDTH-1:0] idx
);

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves an output unassigned (no latch).
    valid = 1'b0;
    blank = 1'b0;
    idx   = '0;
    case (sel)
      FTSD_SEL_DIG0: begin valid = 1'b1; idx = 2'd0; end
      FTSD_SEL_DIG1: begin valid = 1'b1; idx = 2'd1; end
      FTSD_SEL_DIG2: begin valid = 1'b1; idx = 2'd2; end
      FTSD_SEL_DIG3: begin valid = 1'b1; idx = 2'd3; end
      FTSD_BLANK:    blank = 1'b1;
      default:       ;
    endcase
  end

endmodule

// File: rtl/ftsd_scan_rx.sv
// Receive side of the multiplexed 4-digit display scan: debounces select/BCD,
// rebuilds digits and publishes frames. Optional order check: FTSD_SCAN_RX_ORDER_CHECK_EN.
module ftsd_scan_rx #(
  parameter int BCD_BIT_WIDTH = ftsd_scan_rx_pkg::BCD_BIT_WIDTH,
  parameter int FTSD_NUM      = ftsd_scan_rx_pkg::FTSD_NUM,
  parameter int STABLE_CNT    = 4,
  parameter int TIMEOUT_CYC   = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FTSD_NUM-1:0]      ftsd_ctl,
  input  logic [BCD_BIT_WIDTH-1:0] ftsd_in,
  input  logic                     err_clr,
  output logic [BCD_BIT_WIDTH-1:0] out0,
  output logic [BCD_BIT_WIDTH-1:0] out1,
  output logic [BCD_BIT_WIDTH-1:0] out2,
  output logic [BCD_BIT_WIDTH-1:0] out3,
  output logic                     frame_valid,
  output logic                     err_illegal,
  output logic                     err_order,
  output logic                     stall
);

  import ftsd_scan_rx_pkg::*;

  localparam int STB_W  = $clog2(STABLE_CNT + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STB_W-1:0]  STB_MAX  = STB_W'(STABLE_CNT);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

  // Stage-1 sample and the sample before it.
  logic [FTSD_NUM-1:0]      smp_ctl, prv_ctl;
  logic [BCD_BIT_WIDTH-1:0] smp_bcd, prv_bcd;

  logic [STB_W-1:0]  stb_cnt, stb_cnt_nxt;
  logic              same, accept;
  ftsd_sel_t         dec;
  logic              legal_acc, illegal_acc;

  logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
  logic              timeout_hit;

  logic [FTSD_NUM-1:0] seen, seen_nxt;
  logic                frame_fire;

  logic [BCD_BIT_WIDTH-1:0] digit_q [FTSD_NUM];
  logic [BCD_BIT_WIDTH-1:0] out_q   [FTSD_NUM];

  logic frame_valid_q, err_illegal_q, stall_q;

  ftsd_sel_decode u_sel_decode (
    .sel   (smp_ctl),
    .valid (dec.valid),
    .blank (dec.blank),
    .idx   (dec.idx)
  );

  // Stability counter: one acceptance on the edge the count first reaches STABLE_CNT.
  always_comb begin
    same = ({smp_ctl, smp_bcd} == {prv_ctl, prv_bcd});
    if (!same)                  stb_cnt_nxt = STB_W'(1);
    else if (stb_cnt == STB_MAX) stb_cnt_nxt = stb_cnt;
    else                         stb_cnt_nxt = stb_cnt + 1'b1;
    accept      = (stb_cnt_nxt == STB_MAX) && (!same || (stb_cnt != STB_MAX));
    legal_acc   = accept && dec.valid;
    illegal_acc = accept && !dec.valid && !dec.blank;
  end

  // Idle counter saturates at TIMEOUT_CYC; timeout_hit marks the edge it gets there.
  always_comb begin
    idle_cnt_nxt = idle_cnt;
    timeout_hit  = 1'b0;
    if (legal_acc) begin
      idle_cnt_nxt = '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt_nxt = idle_cnt + 1'b1;
      timeout_hit  = (idle_cnt == IDLE_MAX - 1'b1);
    end
  end

  assign frame_fire = &seen;

`ifdef FTSD_SCAN_RX_ORDER_CHECK_EN
  logic [FTSD_SCAN_CTL_BIT_WIDTH-1:0] exp_idx;
  logic                               exp_any;
  logic                               order_bad;
  logic                               err_order_q;

  // The first digit after reset or stall starts the sequence freely.
  assign order_bad = legal_acc && !exp_any && (dec.idx != exp_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_idx     <= '0;
      exp_any     <= 1'b1;
      err_order_q <= 1'b0;
    end else begin
      if (legal_acc) begin
        exp_idx <= dec.idx + 2'd1;
        exp_any <= 1'b0;
      end else if (timeout_hit) begin
        exp_any <= 1'b1;
      end
      if (order_bad)    err_order_q <= 1'b1;
      else if (err_clr) err_order_q <= 1'b0;
    end
  end

  assign err_order = err_order_q;
`else
  assign err_order = 1'b0;
`endif

  // Seen mask: cleared by frame, timeout or order break; the accepted digit is then recorded.
  always_comb begin
    seen_nxt = seen;
    if (frame_fire || timeout_hit) seen_nxt = '0;
`ifdef FTSD_SCAN_RX_ORDER_CHECK_EN
    if (order_bad) seen_nxt = '0;
`endif
    if (legal_acc) seen_nxt[dec.idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_ctl       <= FTSD_BLANK;
      smp_bcd       <= '0;
      prv_ctl       <= FTSD_BLANK;
      prv_bcd       <= '0;
      stb_cnt       <= '0;
      idle_cnt      <= '0;
      seen          <= '0;
      frame_valid_q <= 1'b0;
      err_illegal_q <= 1'b0;
      stall_q       <= 1'b0;
      // NOTE: digit and output arrays are a handful of flops that must read 0 after reset, so they are reset here; a real RAM would not be.
      for (int i = 0; i < FTSD_NUM; i++) begin
        digit_q[i] <= '0;
        out_q[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking, so prv_* captures the pre-edge smp_* value and all state moves together.
      smp_ctl       <= ftsd_ctl;
      smp_bcd       <= ftsd_in;
      prv_ctl       <= smp_ctl;
      prv_bcd       <= smp_bcd;
      stb_cnt       <= stb_cnt_nxt;
      idle_cnt      <= idle_cnt_nxt;
      seen          <= seen_nxt;
      frame_valid_q <= frame_fire;

      if (legal_acc) digit_q[dec.idx] <= smp_bcd;

      if (frame_fire) begin
        for (int i = 0; i < FTSD_NUM; i++) out_q[i] <= digit_q[i];
      end

      if (illegal_acc)  err_illegal_q <= 1'b1;
      else if (err_clr) err_illegal_q <= 1'b0;

      if (legal_acc)        stall_q <= 1'b0;
      else if (timeout_hit) stall_q <= 1'b1;
    end
  end

  assign out0        = out_q[0];
  assign out1        = out_q[1];
  assign out2        = out_q[2];
  assign out3        = out_q[3];
  assign frame_valid = frame_valid_q;
  assign err_illegal = err_illegal_q;
  assign stall       = stall_q;

endmodule

// File: tb/tb_ftsd_scan_rx.sv
// Scoreboard bench for ftsd_scan_rx: expected frames are queued by the stimulus
// and compared by a monitor on every frame_valid pulse.
module tb_ftsd_scan_rx;

  localparam int STB = 4;
  localparam int TO  = 100;
`ifdef FTSD_SCAN_RX_ORDER_CHECK_EN
  localparam logic ORDER_EXP = 1'b1;
`else
  localparam logic ORDER_EXP = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] ftsd_ctl = 4'b1111;
  logic [3:0] ftsd_in  = 4'd0;
  logic       err_clr  = 1'b0;
  logic [3:0] out0, out1, out2, out3;
  logic       frame_valid, err_illegal, err_order, stall;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  ftsd_scan_rx #(
    .BCD_BIT_WIDTH (4),
    .FTSD_NUM      (4),
    .STABLE_CNT    (STB),
    .TIMEOUT_CYC   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ftsd_ctl    (ftsd_ctl),
    .ftsd_in     (ftsd_in),
    .err_clr     (err_clr),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .frame_valid (frame_valid),
    .err_illegal (err_illegal),
    .err_order   (err_order),
    .stall       (stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a select/value pair (called at a negedge) and keep it for n clock edges.
  task automatic hold(input logic [3:0] c, input logic [3:0] b, input int n);
    ftsd_ctl = c;
    ftsd_in  = b;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every frame_valid pulse must match the oldest queued frame {d3,d2,d1,d0}.
  always @(negedge clk) begin
    if (frame_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got 0x%h, expected no frame", {out3, out2, out1, out0});
      end else begin
        mon_exp = exp_q.pop_front();
        check("frame", {16'h0, out3, out2, out1, out0}, {16'h0, mon_exp});
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out",   {16'h0, out3, out2, out1, out0}, 32'h0);
    check("rst_fv",    {31'h0, frame_valid}, 32'h0);
    check("rst_flags", {29'h0, err_illegal, err_order, stall}, 32'h0);
    rst_n = 1'b1;

    // In-order scan 9,4,2,7; frame one edge after the digit-3 acceptance.
    exp_q.push_back(16'h7249);
    hold(4'b0111, 4'd9, 8);
    hold(4'b1011, 4'd4, 8);
    hold(4'b1101, 4'd2, 8);
    hold(4'b1110, 4'd7, STB + 1);
    check("fv_early", {31'h0, frame_valid}, 32'h0);
    hold(4'b1110, 4'd7, 1);
    check("fv_pulse", {31'h0, frame_valid}, 32'h1);
    hold(4'b1110, 4'd7, 1);
    check("fv_one_cycle", {31'h0, frame_valid}, 32'h0);
    check("t1_flags", {29'h0, err_illegal, err_order, stall}, 32'h0);

    // Illegal select 1001, sticky flag, clear, and set-wins-over-clear.
    hold(4'b1111, 4'd0, 2);
    hold(4'b1001, 4'd3, STB);
    check("ill_early", {31'h0, err_illegal}, 32'h0);
    hold(4'b1001, 4'd3, 1);
    check("ill_set", {31'h0, err_illegal}, 32'h1);
    hold(4'b1001, 4'd3, 3);
    check("ill_sticky", {31'h0, err_illegal}, 32'h1);
    err_clr = 1'b1;
    hold(4'b1111, 4'd0, 1);
    err_clr = 1'b0;
    check("ill_clr", {31'h0, err_illegal}, 32'h0);
    hold(4'b1111, 4'd0, 2);
    hold(4'b1001, 4'd3, STB);
    err_clr = 1'b1;
    hold(4'b1001, 4'd3, 1);
    err_clr = 1'b0;
    check("ill_set_wins", {31'h0, err_illegal}, 32'h1);
    err_clr = 1'b1;
    hold(4'b1001, 4'd3, 1);
    err_clr = 1'b0;
    check("ill_clr2", {31'h0, err_illegal}, 32'h0);

    // Partial frame 0,1,2 then blank until timeout; idle is 3 after the last hold.
    hold(4'b0111, 4'd5, 8);
    hold(4'b1011, 4'd5, 8);
    hold(4'b1101, 4'd5, 8);
    hold(4'b1111, 4'd0, TO - 4);
    check("stall_early", {31'h0, stall}, 32'h0);
    hold(4'b1111, 4'd0, 1);
    check("stall_set", {31'h0, stall}, 32'h1);
    check("stall_hold_out", {16'h0, out3, out2, out1, out0}, 32'h7249);

    // After stall the mask restarts: 2,3,0 then digit 1 glitched (5 for 3 cycles, then 6).
    exp_q.push_back(16'h8361);
    hold(4'b1101, 4'd3, STB);
    check("stall_still", {31'h0, stall}, 32'h1);
    hold(4'b1101, 4'd3, 1);
    check("stall_clear", {31'h0, stall}, 32'h0);
    hold(4'b1101, 4'd3, 3);
    hold(4'b1110, 4'd8, 8);
    hold(4'b0111, 4'd1, 8);
    hold(4'b1011, 4'd5, STB - 1);
    hold(4'b1011, 4'd6, 8);

    // Reset mid-frame: digits 0,1 then reset, then 2,3 must not complete a frame.
    hold(4'b0111, 4'd9, 8);
    hold(4'b1011, 4'd2, 8);
    rst_n = 1'b0;
    hold(4'b1111, 4'd0, 1);
    rst_n = 1'b1;
    check("rst2_out", {16'h0, out3, out2, out1, out0}, 32'h0);
    check("rst2_flags", {29'h0, err_illegal, err_order, stall}, 32'h0);
    hold(4'b1101, 4'd3, 8);
    hold(4'b1110, 4'd4, 8);
    check("rst2_no_frame_fv", {31'h0, frame_valid}, 32'h0);

    // Full scan: digits 0,1 complete the mask with post-reset 2,3.
    exp_q.push_back(16'h4365);
    hold(4'b0111, 4'd5, 8);
    hold(4'b1011, 4'd6, 8);
    hold(4'b1101, 4'd7, 8);
    hold(4'b1110, 4'd8, 8);

    // Order 0,2,3,0,1: the out-of-order 2 flags err_order only with the order check built in.
    exp_q.push_back(16'h4569);
    hold(4'b0111, 4'd1, 8);
    hold(4'b1101, 4'd5, STB);
    check("order_early", {31'h0, err_order}, 32'h0);
    hold(4'b1101, 4'd5, 1);
    check("order_flag", {31'h0, err_order}, {31'h0, ORDER_EXP});
    hold(4'b1101, 4'd5, 3);
    hold(4'b1110, 4'd4, 8);
    hold(4'b0111, 4'd9, 8);
    hold(4'b1011, 4'd6, 8);
    err_clr = 1'b1;
    hold(4'b1011, 4'd6, 1);
    err_clr = 1'b0;
    check("order_clr", {31'h0, err_order}, 32'h0);

    hold(4'b1111, 4'd0, 4);
    check("pending_frames", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
